// File: rtl/dm_byte_unit_if.sv
// Bus between the MEM-stage controller and the data memory byte unit.
// Optional AddrErr signal exists only when DM_ALIGN_CHECK_EN is defined.
interface dm_byte_unit_if;
  logic        MemWrite;
  logic [1:0]  OpWidth;
  logic        LoadSigned;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] PC;
  logic [31:0] RData;
`ifdef DM_ALIGN_CHECK_EN
  logic        AddrErr;
`endif

  modport master (
    output MemWrite, OpWidth, LoadSigned, Addr, WData, PC,
`ifdef DM_ALIGN_CHECK_EN
    input  AddrErr,
`endif
    input  RData
  );

  modport slave (
    input  MemWrite, OpWidth, LoadSigned, Addr, WData, PC,
`ifdef DM_ALIGN_CHECK_EN
    output AddrErr,
`endif
    output RData
  );
endinterface

// File: rtl/dm_byte_unit.sv
// MEM-stage data memory: byte-enabled stores into a word array, combinational
// load extraction with sign/zero extension, and a store trace for simulation.
// Optional misalignment checking is enabled by defining DM_ALIGN_CHECK_EN.
module dm_byte_unit #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  dm_byte_unit_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       memArray [DEPTH];
  logic [31:0]       offsetAddr;
  logic [ADDR_W-1:0] wordIdx;
  logic [1:0]        byteSel;
  logic [31:0]       curWord;
  logic [31:0]       laneData;
  logic [31:0]       mergedWord;
  logic [3:0]        byteEn;
  logic [31:0]       loadWord;
  logic              storeOk;
  logic              unusedAddrBits;

  // Sub-word loads: extend a byte or halfword to 32 bits.
  function automatic logic [31:0] extendLoad(input logic [15:0] val,
                                             input logic isHalf,
                                             input logic signExt);
    logic signed [31:0] s16;
    logic signed [31:0] s8;
    s16 = 32'(signed'(val));
    s8  = 32'(signed'(val[7:0]));
    if (isHalf) return signExt ? s16 : {16'b0, val};
    else        return signExt ? s8  : {24'b0, val[7:0]};
  endfunction

  // Addresses outside the array wrap: only the word-index bits are kept.
  assign offsetAddr     = bus.Addr - BASE_ADDR;
  assign wordIdx        = offsetAddr[ADDR_W+1:2];
  assign byteSel        = bus.Addr[1:0];
  assign unusedAddrBits = &{1'b0, offsetAddr[31:ADDR_W+2], offsetAddr[1:0]};
  assign curWord        = memArray[wordIdx];

`ifdef DM_ALIGN_CHECK_EN
  logic misAligned;

  // Word must be 4-byte aligned, halfword 2-byte aligned.
  always_comb begin
    misAligned = 1'b0;
    if (bus.OpWidth == 2'd0)      misAligned = (bus.Addr[1:0] != 2'b00);
    else if (bus.OpWidth == 2'd1) misAligned = bus.Addr[0];
  end

  assign storeOk     = bus.MemWrite & ~misAligned;
  assign bus.AddrErr = reset & misAligned;
`else
  assign storeOk = bus.MemWrite;
`endif

  // Byte enables and replicated write lanes for the selected width.
  always_comb begin
    byteEn   = 4'b0000;
    laneData = bus.WData;
    case (bus.OpWidth)
      2'd0: begin
        laneData = bus.WData;
        if (storeOk) byteEn = 4'b1111;
      end
      2'd1: begin
        laneData = {2{bus.WData[15:0]}};
        if (storeOk) byteEn = bus.Addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        laneData = {4{bus.WData[7:0]}};
        if (storeOk) byteEn = 4'b0001 << byteSel;
      end
      default: begin
        laneData = bus.WData;
        byteEn   = 4'b0000;
      end
    endcase
  end

  // Merge enabled lanes into the current word contents.
  always_comb begin
    mergedWord = curWord;
    for (int k = 0; k < 4; k++) begin
      if (byteEn[k]) mergedWord[k*8 +: 8] = laneData[k*8 +: 8];
    end
  end

  // Word array: asynchronous clear, byte-merged write on the rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) memArray[i] <= 32'h0;
    end else if (|byteEn) begin
      memArray[wordIdx] <= mergedWord;
    end
  end

  // Load extraction; misaligned accesses read at the lower boundary.
  always_comb begin
    loadWord = curWord;
    case (bus.OpWidth)
      2'd1: loadWord = extendLoad(bus.Addr[1] ? curWord[31:16] : curWord[15:0],
                                  1'b1, bus.LoadSigned);
      2'd2: begin
        case (byteSel)
          2'd0:    loadWord = extendLoad({8'b0, curWord[7:0]},   1'b0, bus.LoadSigned);
          2'd1:    loadWord = extendLoad({8'b0, curWord[15:8]},  1'b0, bus.LoadSigned);
          2'd2:    loadWord = extendLoad({8'b0, curWord[23:16]}, 1'b0, bus.LoadSigned);
          default: loadWord = extendLoad({8'b0, curWord[31:24]}, 1'b0, bus.LoadSigned);
        endcase
      end
      default: loadWord = curWord;
    endcase
  end

  assign bus.RData = reset ? loadWord : 32'h0;

`ifndef SYNTHESIS
  // Store trace for the output checker; suppressed writes print nothing.
  always @(posedge clk) begin
    if (reset && (|byteEn))
      $display("%d@%h: *%h <= %h", $time, bus.PC, {bus.Addr[31:2], 2'b00}, mergedWord);
  end
`endif

endmodule

// File: tb/tb_dm_byte_unit.sv
// Directed, table-driven bench for dm_byte_unit with hand-written sequences
// for reset-during-store and (when DM_ALIGN_CHECK_EN is defined) alignment.
module tb_dm_byte_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_byte_unit_if bus();

  dm_byte_unit #(.ADDR_W(10), .BASE_ADDR(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nRun  = 0;
  int nFail = 0;

  typedef struct {
    logic        memWrite;
    logic [1:0]  opWidth;
    logic        loadSigned;
    logic [31:0] addr;
    logic [31:0] wData;
    logic        chk;
    logic [31:0] expRData;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(logic mw, logic [1:0] ow, logic ls,
                                 logic [31:0] a, logic [31:0] wd,
                                 logic c, logic [31:0] e);
    vec_t v;
    v.memWrite = mw; v.opWidth = ow; v.loadSigned = ls;
    v.addr = a; v.wData = wd; v.chk = c; v.expRData = e;
    vecs.push_back(v);
  endfunction

  task automatic drive(logic mw, logic [1:0] ow, logic ls,
                       logic [31:0] a, logic [31:0] wd);
    bus.MemWrite   = mw;
    bus.OpWidth    = ow;
    bus.LoadSigned = ls;
    bus.Addr       = a;
    bus.WData      = wd;
    bus.PC         = 32'h0000_1000 + a;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Stores (chk=0) take effect at the edge following the cycle they are driven.
    addVec(0, 2'd0, 0, 32'h0000_0000, 32'h0, 1, 32'h0000_0000);
    addVec(0, 2'd0, 0, 32'h0000_3FFC, 32'h0, 1, 32'h0000_0000);
    addVec(0, 2'd0, 0, 32'h0000_1234, 32'h0, 1, 32'h0000_0000);
    addVec(1, 2'd0, 0, 32'h0000_0010, 32'h8899_AABB, 0, 32'h0);
    addVec(0, 2'd0, 0, 32'h0000_0010, 32'h0, 1, 32'h8899_AABB);
    addVec(1, 2'd2, 0, 32'h0000_0012, 32'h0000_0055, 0, 32'h0);
    addVec(0, 2'd0, 0, 32'h0000_0010, 32'h0, 1, 32'h8855_AABB);
    addVec(0, 2'd2, 1, 32'h0000_0013, 32'h0, 1, 32'hFFFF_FF88);
    addVec(0, 2'd2, 0, 32'h0000_0013, 32'h0, 1, 32'h0000_0088);
    addVec(1, 2'd1, 0, 32'h0000_0022, 32'h0000_F00D, 0, 32'h0);
    addVec(0, 2'd0, 0, 32'h0000_0020, 32'h0, 1, 32'hF00D_0000);
    addVec(0, 2'd1, 1, 32'h0000_0022, 32'h0, 1, 32'hFFFF_F00D);
    addVec(0, 2'd1, 1, 32'h0000_0020, 32'h0, 1, 32'h0000_0000);
    addVec(1, 2'd0, 0, 32'h0000_0030, 32'h1234_5678, 0, 32'h0);
    addVec(1, 2'd3, 0, 32'h0000_0030, 32'hDEAD_BEEF, 0, 32'h0);
    addVec(0, 2'd0, 0, 32'h0000_0030, 32'h0, 1, 32'h1234_5678);
    addVec(0, 2'd3, 1, 32'h0000_0030, 32'h0, 1, 32'h1234_5678);
    addVec(1, 2'd0, 0, 32'h0000_4010, 32'hCAFE_F00D, 0, 32'h0);
    addVec(0, 2'd0, 0, 32'h0000_0010, 32'h0, 1, 32'hCAFE_F00D);
    addVec(0, 2'd2, 0, 32'h0000_0011, 32'h0, 1, 32'h0000_00F0);
    addVec(0, 2'd1, 0, 32'h0000_0012, 32'h0, 1, 32'h0000_CAFE);
    addVec(0, 2'd2, 1, 32'h0000_0010, 32'h0, 1, 32'h0000_000D);
    addVec(1, 2'd1, 0, 32'h0000_0030, 32'hFFFF_1111, 0, 32'h0);
    addVec(0, 2'd0, 0, 32'h0000_0030, 32'h0, 1, 32'h1234_1111);
    addVec(1, 2'd2, 0, 32'h0000_0031, 32'h0000_00AB, 0, 32'h0);
    addVec(0, 2'd0, 0, 32'h0000_0030, 32'h0, 1, 32'h1234_AB11);
    addVec(0, 2'd1, 1, 32'h0000_0032, 32'h0, 1, 32'h0000_1234);

    // Reset phase: array clears asynchronously, RData forced low.
    drive(0, 2'd0, 0, 32'h0000_1234, 32'h0);
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check("resetRead", bus.RData, 32'h0);
`ifdef DM_ALIGN_CHECK_EN
    drive(0, 2'd0, 0, 32'h0000_0042, 32'h0);
    #1 check("resetAddrErr", {31'b0, bus.AddrErr}, 32'h0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].memWrite, vecs[i].opWidth, vecs[i].loadSigned,
            vecs[i].addr, vecs[i].wData);
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d", i), bus.RData, vecs[i].expRData);
    end

    // Same-cycle read/write at one index: old data before the edge, new after.
    @(negedge clk);
    drive(1, 2'd0, 0, 32'h0000_0030, 32'hA5A5_5A5A);
    #1 check("rawBefore", bus.RData, 32'h1234_AB11);
    @(posedge clk);
    #1 check("rawAfter", bus.RData, 32'hA5A5_5A5A);

`ifdef DM_ALIGN_CHECK_EN
    @(negedge clk);
    drive(1, 2'd0, 0, 32'h0000_0040, 32'h5555_AAAA);
    @(negedge clk);
    drive(1, 2'd0, 0, 32'h0000_0042, 32'h1111_2222);
    #1 check("alignWordErr", {31'b0, bus.AddrErr}, 32'h1);
    @(negedge clk);
    drive(0, 2'd0, 0, 32'h0000_0040, 32'h0);
    #1 check("alignNoStore", bus.RData, 32'h5555_AAAA);
    drive(0, 2'd1, 0, 32'h0000_0041, 32'h0);
    #1 check("alignHalfErr", {31'b0, bus.AddrErr}, 32'h1);
    check("alignHalfData", bus.RData, 32'h0000_AAAA);
    drive(0, 2'd2, 0, 32'h0000_0041, 32'h0);
    #1 check("alignByteOk", {31'b0, bus.AddrErr}, 32'h0);
`endif

    // Reset asserted before the edge of a pending store: nothing is written.
    @(negedge clk);
    drive(1, 2'd0, 0, 32'h0000_0044, 32'h1111_2222);
    #2 reset = 1'b0;
    #1 check("midResetRData", bus.RData, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 2'd0, 0, 32'h0000_0044, 32'h0);
    reset = 1'b1;
    #1 check("midResetNoWrite", bus.RData, 32'h0);
    drive(0, 2'd0, 0, 32'h0000_0010, 32'h0);
    #1 check("midResetClr10", bus.RData, 32'h0);
    drive(0, 2'd0, 0, 32'h0000_0030, 32'h0);
    #1 check("midResetClr30", bus.RData, 32'h0);

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule

// File: doc/dm_byte_unit.md
Name: dm_byte_unit

Overview:
- MEM-stage data memory. Sits directly downstream of the MEM-stage controller and consumes its MemWrite, OpWidth and LoadSigned decode.
- Performs word, halfword and byte stores through per-byte write enables into a synchronous word array.
- Returns a combinationally extracted and extended load value to the MEM/WB pipeline register.
- Provides a store trace for the course-style output checker.

Parameters:
- ADDR_W, 10, word-index width; array holds 2^ADDR_W 32-bit words (default 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  pipeline clock; all writes on rising edge.
- reset  input  1  asynchronous, active-low; clears the whole array.
- MemWrite  input  1  store enable from the MEM controller.
- OpWidth  input  2  access width: 0 = word, 1 = halfword, 2 = byte, 3 = reserved.
- LoadSigned  input  1  1 = sign-extend sub-word load, 0 = zero-extend; ignored for word width.
- Addr  input  32  byte address (ALU result from EX/MEM).
- WData  input  32  store data; low-order bytes are used for sub-word stores.
- PC  input  32  PC of the MEM-stage instruction; used only for trace.
- RData  output  32  extracted/extended load data.
- AddrErr  output  1  misaligned-access flag; present only with the optional feature.

Behaviour:
- Index and byte select:
  - idx = (Addr - BASE_ADDR)[ADDR_W+1:2]. Upper bits are ignored, so out-of-range addresses wrap modulo array size.
  - bsel = Addr[1:0].
- Byte enables (be[3:0]) when MemWrite = 1:
  - word: 4'b1111.
  - half: 4'b0011 when Addr[1] = 0, else 4'b1100.
  - byte: 4'b0001 shifted left by bsel.
  - reserved (3): 4'b0000, no write.
- Store merge:
  - Write lane k = WData[7:0] for byte, WData[15:0] for half (replicated to both halves), WData for word.
  - Only lanes with be[k] = 1 are updated, at the rising edge of clk.
  - Non-enabled lanes keep their prior value.
- Load path:
  - Combinational from mem[idx], zero cycles latency.
  - word: full word.
  - half: halfword at Addr[1], extended to 32 bits by LoadSigned.
  - byte: byte at bsel, extended to 32 bits by LoadSigned.
  - reserved: full word.
- Read/write same cycle and same idx: RData shows the old contents until the edge and the new contents after it. There is no internal forwarding; the hazard unit owns this.
- Reset:
  - While reset = 0, every word reads 0 and RData = 0 for any Addr.
  - A rising edge with reset = 0 performs no write.
  - Deassertion is synchronised by the top level.
- Trace:
  - On each write edge with any be bit set, issue $display("%d@%h: *%h <= %h", $time, PC, {Addr[31:2],2'b00}, merged_word).
  - merged_word is the full 32-bit post-merge value.
  - No trace is issued for suppressed writes.

Optional Feature:
- Macro DM_ALIGN_CHECK_EN.
- Defined:
  - Misalignment is word with Addr[1:0] != 0, or half with Addr[0] = 1.
  - On misalignment, AddrErr = 1 combinationally and be is forced to 0 (store suppressed, no trace).
  - A misaligned load still drives RData as if aligned to the lower boundary.
  - AddrErr = 0 during reset.
- Undefined:
  - AddrErr port absent.
  - Addr[1:0] is ignored for word accesses and Addr[0] is ignored for halfword accesses; misaligned stores proceed on the truncated alignment.

Test Plan:
- Reset low for 2 cycles, then release; read Addr = 0x0, 0x3FFC, 0x1234 -> RData = 0 for each.
- Word store Addr = 0x10, WData = 0x8899AABB, then word load Addr = 0x10 -> RData = 0x8899AABB; trace line shows *00000010 <= 8899aabb.
- Word 0x8899AABB at 0x10; byte store 0x55 at Addr 0x12 -> word reads 0x8855AABB.
  - Byte load 0x13 with LoadSigned = 1 -> 0xFFFFFF88.
  - Same load with LoadSigned = 0 -> 0x00000088.
- Half store WData = 0x0000F00D at Addr 0x22, word previously 0 -> word reads 0xF00D0000.
  - Half load 0x22 with LoadSigned = 1 -> 0xFFFFF00D.
  - Half load 0x20 with LoadSigned = 1 -> 0x00000000.
- MemWrite = 1, OpWidth = 3 at 0x30 holding 0x12345678 -> contents unchanged, no trace.
- Word store at 0x4010 (ADDR_W = 10) -> wraps to 0x10.
- Assert reset mid-store (reset low before the edge) -> no write; all reads 0 afterwards.
- With DM_ALIGN_CHECK_EN: word store at 0x42 -> AddrErr = 1, memory unchanged, no trace.
- With DM_ALIGN_CHECK_EN: half load at 0x41 -> AddrErr = 1.
- With DM_ALIGN_CHECK_EN: byte access at 0x41 -> AddrErr = 0.
